// File: rtl/ultrasonic_hit_detector_if.sv
// Sensor pins plus the hit-event valid/ack bus between the ultrasonic detector and the game datapath.
// The master side is the datapath or bench; the slave side is the detector.
interface ultrasonic_hit_detector_if #(
    parameter int NUM_SENSORS = 4
);
    logic                   enable;
    logic [NUM_SENSORS-1:0] echo;
    logic                   hit_ack;
    logic [NUM_SENSORS-1:0] trig;
    logic [3:0]             box_address;
    logic                   hit_valid;
    logic                   busy;

    modport master (
        output enable,
        output echo,
        output hit_ack,
        input  trig,
        input  box_address,
        input  hit_valid,
        input  busy
    );

    modport slave (
        input  enable,
        input  echo,
        input  hit_ack,
        output trig,
        output box_address,
        output hit_valid,
        output busy
    );
endinterface

// File: rtl/ultrasonic_hit_detector.sv
// Round-robin HC-SR04 poller: triggers one sensor at a time and times its echo pulse.
// It confirms hits over consecutive pings and presents one event per hand under valid/ack.
module ultrasonic_hit_detector #(
    parameter int NUM_SENSORS  = 4,
    parameter int TRIG_CYCLES  = 500,
    parameter int ECHO_TIMEOUT = 1_500_000,
    parameter int HIT_MIN      = 3_000,
    parameter int HIT_MAX      = 29_000,
    parameter int GAP_CYCLES   = 500_000,
    parameter int HIT_CONFIRM  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    ultrasonic_hit_detector_if.slave bus
);
    localparam int CNT_MAX_A = (ECHO_TIMEOUT > GAP_CYCLES) ? ECHO_TIMEOUT : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TRIG_CYCLES) ? CNT_MAX_A : TRIG_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_MIN   = CNT_W'(HIT_MIN);
    localparam logic [CNT_W-1:0] WIN_MAX   = CNT_W'(HIT_MAX);
    localparam logic [2:0]       CONF_FULL = 3'(HIT_CONFIRM);
    localparam logic [3:0]       SEL_LAST  = 4'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       counter_reg, counter_next;
    logic [3:0]             sel_reg, sel_next;
    logic [NUM_SENSORS-1:0] echo_meta_reg, echo_sync_reg, echo_last_reg;
    logic [NUM_SENSORS-1:0] sel_onehot;
    logic [NUM_SENSORS-1:0] fire_vec;
    logic                   echo_sel, echo_rise;
    logic                   reading_valid, reading_hit;
    logic                   fire;
    logic                   hit_valid_reg;
    logic [3:0]             box_address_reg;

    // Two-flop synchronizer, plus one more stage so a rise is a synced 0->1 transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            echo_meta_reg <= '0;
            echo_sync_reg <= '0;
            echo_last_reg <= '0;
        end else begin
            echo_meta_reg <= bus.echo;
            echo_sync_reg <= echo_meta_reg;
            echo_last_reg <= echo_sync_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_sel
            assign sel_onehot[gi] = (sel_reg == 4'(gi));
        end
    endgenerate

    assign echo_sel  = |(echo_sync_reg & sel_onehot);
    assign echo_rise = echo_sel & ~(|(echo_last_reg & sel_onehot));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            sel_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            sel_reg     <= sel_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        sel_next      = sel_reg;
        reading_valid = 1'b0;
        reading_hit   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.enable) begin
                    state_next   = S_TRIG;
                    counter_next = '0;
                end
            end
            S_TRIG: begin
                if (counter_reg >= TRIG_LAST) begin
                    state_next   = S_WAIT_RISE;
                    counter_next = '0;
                end else begin
                    counter_next = counter_reg + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                // The rise cycle is the first high sample, hence the count starts at 1.
                if (echo_rise) begin
                    state_next   = S_MEASURE;
                    counter_next = CNT_W'(1);
                end else if (counter_reg >= ECHO_LAST) begin
                    reading_valid = 1'b1;
                    state_next    = S_GAP;
                    counter_next  = '0;
                end else begin
                    counter_next = counter_reg + 1'b1;
                end
            end
            S_MEASURE: begin
                if (!echo_sel) begin
                    reading_valid = 1'b1;
                    reading_hit   = (counter_reg >= WIN_MIN) && (counter_reg <= WIN_MAX);
                    state_next    = S_GAP;
                    counter_next  = '0;
                end else if (counter_reg >= ECHO_LAST) begin
                    reading_valid = 1'b1;
                    state_next    = S_GAP;
                    counter_next  = '0;
                end else begin
                    counter_next = counter_reg + 1'b1;
                end
            end
            S_GAP: begin
                if (counter_reg >= GAP_LAST) begin
                    sel_next     = (sel_reg >= SEL_LAST) ? 4'd0 : sel_reg + 4'd1;
                    state_next   = bus.enable ? S_TRIG : S_IDLE;
                    counter_next = '0;
                end else begin
                    counter_next = counter_reg + 1'b1;
                end
            end
            default: begin
                state_next   = S_IDLE;
                counter_next = '0;
            end
        endcase
    end

    // Per-sensor confirm count and re-arm flag; a sensor fires once per continuous hit run.
    generate
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
            logic [2:0] conf_reg;
            logic [2:0] conf_next;
            logic       armed_reg;

            assign conf_next = (conf_reg >= CONF_FULL) ? CONF_FULL : conf_reg + 3'd1;
            assign fire_vec[gi] = sel_onehot[gi] & reading_valid & reading_hit &
                                  (conf_next == CONF_FULL) & armed_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    conf_reg  <= '0;
                    armed_reg <= 1'b1;
                end else if (sel_onehot[gi] && reading_valid) begin
                    if (reading_hit) begin
                        conf_reg <= conf_next;
                        if (conf_next == CONF_FULL) begin
                            armed_reg <= 1'b0;
                        end
                    end else begin
                        conf_reg  <= '0;
                        armed_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign fire = |fire_vec;

    // A confirm that finds the slot occupied and unacked is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_valid_reg   <= 1'b0;
            box_address_reg <= 4'd0;
        end else if (fire && (!hit_valid_reg || bus.hit_ack)) begin
            hit_valid_reg   <= 1'b1;
            box_address_reg <= sel_reg + 4'd1;
        end else if (hit_valid_reg && bus.hit_ack) begin
            hit_valid_reg   <= 1'b0;
            box_address_reg <= 4'd0;
        end
    end

    assign bus.trig        = (state_reg == S_TRIG) ? sel_onehot : '0;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.hit_valid   = hit_valid_reg;
    assign bus.box_address = box_address_reg;
endmodule

// File: tb/tb_ultrasonic_hit_detector.sv
// Directed bench for ultrasonic_hit_detector: a ping table with hand-computed event expectations,
// plus hand sequences for trigger schedule, exact event timing, ack/confirm collision, reset and enable.
module tb_ultrasonic_hit_detector;
    localparam int NS   = 4;
    localparam int TRIG = 4;
    localparam int TO   = 200;
    localparam int HMIN = 10;
    localparam int HMAX = 50;
    localparam int GAP  = 20;
    localparam int CONF = 2;
    localparam int PERIOD_CYC = TRIG + TO + GAP;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    ultrasonic_hit_detector_if #(.NUM_SENSORS(NS)) bus_if ();

    ultrasonic_hit_detector #(
        .NUM_SENSORS (NS),
        .TRIG_CYCLES (TRIG),
        .ECHO_TIMEOUT(TO),
        .HIT_MIN     (HMIN),
        .HIT_MAX     (HMAX),
        .GAP_CYCLES  (GAP),
        .HIT_CONFIRM (CONF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int sensor;
        int width;
        bit ack;
        int exp_valid;
        int exp_box;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int trig_index();
        int s;
        s = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (bus_if.trig[i]) s = i;
        end
        return s;
    endfunction

    task automatic wait_trig(output int s);
        s = -1;
        for (int i = 0; i < 2 * PERIOD_CYC && s < 0; i++) begin
            @(negedge clock);
            if (bus_if.trig != '0) s = trig_index();
        end
        if (s < 0) check("trig_timeout", 0, 1);
    endtask

    task automatic wait_trig_fall();
        int n;
        n = 0;
        while (bus_if.trig != '0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (bus_if.trig != '0) check("trig_fall_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus_if.echo   = '0;
        bus_if.hit_ack = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Waits for the next ping, checks its sensor, then drives a width-clock echo 3 clocks after trig.
    task automatic run_ping(input int exp_s, input int width);
        int s;
        wait_trig(s);
        check($sformatf("ping_sensor_%0d", exp_s), s, exp_s);
        if (s >= 0) begin
            wait_trig_fall();
            repeat (3) @(negedge clock);
            if (width > 0) begin
                bus_if.echo = NS'(1 << s);
                repeat (width) @(negedge clock);
                bus_if.echo = '0;
            end
        end
    endtask

    initial begin
        int s;
        int t_prev;
        int t_now;
        int hi;
        int seen;

        // Ping table: sensor, echo width (0 = none), ack after check, expected hit_valid / box_address.
        vecs[0]  = '{0,  30, 1'b0, 0, 0};
        vecs[1]  = '{1,   0, 1'b0, 0, 0};
        vecs[2]  = '{2,  30, 1'b0, 0, 0};
        vecs[3]  = '{3,   9, 1'b0, 0, 0};
        vecs[4]  = '{0,  30, 1'b1, 1, 1};
        vecs[5]  = '{1,   0, 1'b0, 0, 0};
        vecs[6]  = '{2,  30, 1'b1, 1, 3};
        vecs[7]  = '{3,  51, 1'b0, 0, 0};
        vecs[8]  = '{0,  30, 1'b0, 0, 0};
        vecs[9]  = '{1,  10, 1'b0, 0, 0};
        vecs[10] = '{2,   0, 1'b0, 0, 0};
        vecs[11] = '{3,  50, 1'b0, 0, 0};
        vecs[12] = '{0,  80, 1'b0, 0, 0};
        vecs[13] = '{1,  50, 1'b0, 1, 2};
        vecs[14] = '{2, 210, 1'b0, 1, 2};
        vecs[15] = '{3,  10, 1'b0, 1, 2};
        vecs[16] = '{0,  30, 1'b0, 1, 2};
        vecs[17] = '{1,  30, 1'b1, 1, 2};
        vecs[18] = '{2,  30, 1'b0, 0, 0};
        vecs[19] = '{3,  30, 1'b0, 0, 0};
        vecs[20] = '{0,  30, 1'b1, 1, 1};
        vecs[21] = '{1,   0, 1'b0, 0, 0};

        bus_if.enable  = 1'b0;
        bus_if.echo    = '0;
        bus_if.hit_ack = 1'b0;
        reset          = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_trig", int'(bus_if.trig), 0);
        check("reset_box", int'(bus_if.box_address), 0);
        check("reset_valid", int'(bus_if.hit_valid), 0);
        check("reset_busy", int'(bus_if.busy), 0);

        // Free-running schedule with no echoes.
        reset = 1'b0;
        bus_if.enable = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_trig(s);
            t_now = cyc;
            check($sformatf("sched_trig_%0d", k), int'(bus_if.trig), 1 << (k % NS));
            hi = 0;
            while (bus_if.trig != '0 && hi < 50) begin
                hi++;
                @(negedge clock);
            end
            check($sformatf("sched_width_%0d", k), hi, TRIG);
            if (k > 0) check($sformatf("sched_spacing_%0d", k), t_now - t_prev, PERIOD_CYC);
            t_prev = t_now;
            $display("[TB] sched ping %0d sensor %0d high %0d clocks", k, s, hi);
        end
        check("sched_no_event", int'(bus_if.hit_valid), 0);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            run_ping(vecs[i].sensor, vecs[i].width);
            repeat (5) @(negedge clock);
            check($sformatf("vec%0d_valid", i), int'(bus_if.hit_valid), vecs[i].exp_valid);
            check($sformatf("vec%0d_box", i), int'(bus_if.box_address), vecs[i].exp_box);
            $display("[TB] vec %0d sensor %0d width %0d -> hit_valid=%0d box_address=%0d",
                     i, vecs[i].sensor, vecs[i].width, bus_if.hit_valid, bus_if.box_address);
            if (vecs[i].ack) begin
                bus_if.hit_ack = 1'b1;
                @(negedge clock);
                bus_if.hit_ack = 1'b0;
                check($sformatf("vec%0d_ack_valid", i), int'(bus_if.hit_valid), 0);
                check($sformatf("vec%0d_ack_box", i), int'(bus_if.box_address), 0);
            end
        end

        // Exact event latency for sensor 2, then an ack colliding with a sensor-3 confirm.
        do_reset();
        run_ping(0, 0);
        run_ping(1, 0);
        run_ping(2, 30);
        run_ping(3, 30);
        run_ping(0, 0);
        run_ping(1, 0);
        run_ping(2, 30);
        repeat (2) @(negedge clock);
        check("lat_before_valid", int'(bus_if.hit_valid), 0);
        @(negedge clock);
        check("lat_valid", int'(bus_if.hit_valid), 1);
        check("lat_box", int'(bus_if.box_address), 3);
        $display("[TB] latency event hit_valid=%0d box_address=%0d", bus_if.hit_valid, bus_if.box_address);
        run_ping(3, 30);
        repeat (2) @(negedge clock);
        check("collide_pre_box", int'(bus_if.box_address), 3);
        bus_if.hit_ack = 1'b1;
        @(negedge clock);
        bus_if.hit_ack = 1'b0;
        check("collide_valid", int'(bus_if.hit_valid), 1);
        check("collide_box", int'(bus_if.box_address), 4);
        $display("[TB] collide event hit_valid=%0d box_address=%0d", bus_if.hit_valid, bus_if.box_address);

        // Reset while measuring sensor 0's echo.
        wait_trig(s);
        check("mreset_sensor", s, 0);
        wait_trig_fall();
        repeat (3) @(negedge clock);
        bus_if.echo = NS'(1);
        repeat (10) @(negedge clock);
        check("mreset_busy_before", int'(bus_if.busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check("mreset_trig", int'(bus_if.trig), 0);
        check("mreset_valid", int'(bus_if.hit_valid), 0);
        check("mreset_busy", int'(bus_if.busy), 0);
        check("mreset_box", int'(bus_if.box_address), 0);
        bus_if.echo = '0;
        reset = 1'b0;
        $display("[TB] reset in MEASURE busy=%0d hit_valid=%0d", bus_if.busy, bus_if.hit_valid);

        // Enable dropped in WAIT_RISE: the ping and gap complete, then idle with sel kept.
        wait_trig(s);
        check("en_sensor", s, 0);
        wait_trig_fall();
        repeat (5) @(negedge clock);
        bus_if.enable = 1'b0;
        repeat (150) @(negedge clock);
        check("en_busy_mid", int'(bus_if.busy), 1);
        repeat (80) @(negedge clock);
        check("en_busy_idle", int'(bus_if.busy), 0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus_if.trig != '0) seen = 1;
        end
        check("en_no_trig", seen, 0);
        bus_if.enable = 1'b1;
        wait_trig(s);
        check("en_resume_sensor", s, 1);
        $display("[TB] enable resume sensor %0d", s);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
